// File: rtl/msf_encoder.sv
// MSF time-signal transmitter: turns shadowed BCD time fields into the
// per-second carrier on/off keying, with its own ms and second-of-minute counters.
module msf_encoder #(
    parameter int CYCLES_PER_SEC = 1000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [7:0] year_bcd_i,
    input  logic [4:0] month_bcd_i,
    input  logic [5:0] day_bcd_i,
    input  logic [2:0] weekday_i,
    input  logic [5:0] hour_bcd_i,
    input  logic [6:0] minute_bcd_i,
    input  logic       bst_i,
    input  logic       bst_warn_i,
    output logic       carrier_o,
    output logic [5:0] sec_o,
    output logic       minute_o,
    output logic       load_o
);

    localparam int UNIT = CYCLES_PER_SEC / 10;
    localparam int MSW  = $clog2(CYCLES_PER_SEC);

    localparam logic [MSW-1:0] MS_LAST = MSW'(CYCLES_PER_SEC - 1);
    localparam logic [MSW-1:0] SLOT1   = MSW'(UNIT);
    localparam logic [MSW-1:0] SLOT2   = MSW'(2 * UNIT);
    localparam logic [MSW-1:0] SLOT3   = MSW'(3 * UNIT);
    localparam logic [MSW-1:0] SLOT5   = MSW'(5 * UNIT);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [MSW-1:0] ms_q, ms_d;
    logic [5:0]     sec_q, sec_d;
    logic           carrier_q, carrier_d;
    logic           minute_q, minute_d;
    logic           load_q, load_d;
    logic           capture;

    logic [7:0] year_q;
    logic [4:0] month_q;
    logic [5:0] day_q;
    logic [2:0] wday_q;
    logic [5:0] hour_q;
    logic [6:0] min_q;
    logic       bst_q, warn_q;

    logic [34:0] fields;
    logic [63:0] a_vec, b_vec;
    logic        off;

    assign fields = {year_q, month_q, day_q, wday_q, hour_q, min_q};

    // A bits 17..51 carry the fields MSB first; 52..59 are the fixed 01111110 marker
    always_comb begin
        a_vec = '0;
        for (int i = 0; i < 35; i++) a_vec[17+i] = fields[34-i];
        a_vec[58:53] = '1;
        b_vec = '0;
        b_vec[53] = warn_q;
        b_vec[54] = ~^year_q;
        b_vec[55] = ~^{month_q, day_q};
        b_vec[56] = ~^wday_q;
        b_vec[57] = ~^{hour_q, min_q};
        b_vec[58] = bst_q;
    end

    always_comb begin
        state_d  = state_q;
        ms_d     = ms_q;
        sec_d    = sec_q;
        minute_d = 1'b0;
        load_d   = 1'b0;
        capture  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ms_d  = '0;
                sec_d = '0;
                if (en_i) begin
                    state_d  = S_RUN;
                    minute_d = 1'b1;
                    load_d   = 1'b1;
                    capture  = 1'b1;
                end
            end
            default: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                    ms_d    = '0;
                    sec_d   = '0;
                end else if (ms_q == MS_LAST) begin
                    ms_d = '0;
                    if (sec_q == 6'd59) begin
                        sec_d    = '0;
                        minute_d = 1'b1;
                        load_d   = 1'b1;
                        capture  = 1'b1;
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    ms_d = ms_q + MSW'(1);
                end
            end
        endcase
    end

    // Keying is evaluated on the next (sec, ms) so carrier_o lines up with sec_o.
    // Second 0 never consults A/B, so a same-edge shadow reload cannot disturb it.
    always_comb begin
        if (sec_d == 6'd0)
            off = (ms_d < SLOT5);
        else
            off = (ms_d < SLOT1)
                | ((ms_d < SLOT2) & a_vec[sec_d])
                | ((ms_d >= SLOT2) & (ms_d < SLOT3) & b_vec[sec_d]);
        carrier_d = (state_d == S_IDLE) ? 1'b1 : ~off;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ms_q      <= '0;
            sec_q     <= '0;
            carrier_q <= 1'b1;
            minute_q  <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ms_q      <= ms_d;
            sec_q     <= sec_d;
            carrier_q <= carrier_d;
            minute_q  <= minute_d;
            load_q    <= load_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            year_q  <= '0;
            month_q <= '0;
            day_q   <= '0;
            wday_q  <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            bst_q   <= 1'b0;
            warn_q  <= 1'b0;
        end else if (capture) begin
            year_q  <= year_bcd_i;
            month_q <= month_bcd_i;
            day_q   <= day_bcd_i;
            wday_q  <= weekday_i;
            hour_q  <= hour_bcd_i;
            min_q   <= minute_bcd_i;
            bst_q   <= bst_i;
            warn_q  <= bst_warn_i;
        end
    end

    assign carrier_o = carrier_q;
    assign sec_o     = sec_q;
    assign minute_o  = minute_q;
    assign load_o    = load_q;

endmodule

// File: tb/tb_msf_encoder.sv
// Scoreboard bench for msf_encoder: a frame-level model pushes the expected
// outputs of every cycle; a negedge monitor pops and compares them.
module tb_msf_encoder;

    localparam int CPS  = 20;
    localparam int UNIT = CPS / 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] year  = '0;
    logic [4:0] month = '0;
    logic [5:0] day   = '0;
    logic [2:0] wd    = '0;
    logic [5:0] hour  = '0;
    logic [6:0] minute = '0;
    logic       bst = 1'b0, warn = 1'b0;

    logic       carrier_o, minute_o, load_o;
    logic [5:0] sec_o;

    always #5 clk = ~clk;

    msf_encoder #(.CYCLES_PER_SEC(CPS)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .year_bcd_i(year), .month_bcd_i(month), .day_bcd_i(day),
        .weekday_i(wd), .hour_bcd_i(hour), .minute_bcd_i(minute),
        .bst_i(bst), .bst_warn_i(warn),
        .carrier_o(carrier_o), .sec_o(sec_o),
        .minute_o(minute_o), .load_o(load_o)
    );

    typedef struct {
        bit car;
        int sec;
        bit mn;
        bit ld;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_pass = 0, n_total = 0;

    // model state: running flag, second, ms, pulses, shadow frame contents
    bit          m_run = 0, m_min = 0, m_ld = 0;
    int          m_s = 0, m_ms = 0;
    logic [34:0] sh_f = '0;
    bit          sh_bst = 0, sh_warn = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    function automatic bit odd_par_bit(input logic [34:0] v);
        return ($countones(v) % 2) == 0;
    endfunction

    function automatic bit model_carrier();
        bit a[60];
        bit b[60];
        int slot;
        if (!m_run) return 1'b1;
        foreach (a[i]) begin a[i] = 0; b[i] = 0; end
        for (int i = 0; i < 35; i++) a[17+i] = sh_f[34-i];
        for (int i = 53; i <= 58; i++) a[i] = 1;
        b[53] = sh_warn;
        b[54] = odd_par_bit({27'b0, sh_f[34:27]});
        b[55] = odd_par_bit({24'b0, sh_f[26:16]});
        b[56] = odd_par_bit({32'b0, sh_f[15:13]});
        b[57] = odd_par_bit({22'b0, sh_f[12:0]});
        b[58] = sh_bst;
        slot = m_ms / UNIT;
        if (m_s == 0) return slot >= 5;
        if (slot == 0) return 1'b0;
        if (slot == 1) return !a[m_s];
        if (slot == 2) return !b[m_s];
        return 1'b1;
    endfunction

    task automatic capture_fields();
        sh_f    = {year, month, day, wd, hour, minute};
        sh_bst  = bst;
        sh_warn = warn;
    endtask

    // Advance the model by one clock using the inputs sampled at this edge
    task automatic tick();
        exp_t x;
        @(posedge clk);
        m_min = 0;
        m_ld  = 0;
        if (rst) begin
            m_run = 0; m_s = 0; m_ms = 0;
            sh_f = '0; sh_bst = 0; sh_warn = 0;
        end else if (!m_run) begin
            if (en) begin
                m_run = 1; m_s = 0; m_ms = 0; m_min = 1; m_ld = 1;
                capture_fields();
            end
        end else if (!en) begin
            m_run = 0; m_s = 0; m_ms = 0;
        end else begin
            m_ms++;
            if (m_ms == CPS) begin
                m_ms = 0;
                m_s  = (m_s + 1) % 60;
                if (m_s == 0) begin
                    m_min = 1; m_ld = 1;
                    capture_fields();
                end
            end
        end
        x.car = model_carrier();
        x.sec = m_s;
        x.mn  = m_min;
        x.ld  = m_ld;
        exp_q.push_back(x);
        #1;
    endtask

    task automatic run_until(input int s, input int ms, input int limit);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(m_run && m_s == s && m_ms == ms) && n < limit);
        if (!(m_run && m_s == s && m_ms == ms)) check("run_until_timeout", 0, 1);
    endtask

    task automatic rand_fields();
        year   = 8'($urandom);
        month  = 5'($urandom);
        day    = 6'($urandom);
        wd     = 3'($urandom);
        hour   = 6'($urandom);
        minute = 7'($urandom);
        bst    = 1'($urandom);
        warn   = 1'($urandom);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("carrier", {31'b0, carrier_o}, {31'b0, e.car});
            check("sec",     {26'b0, sec_o},     32'(e.sec));
            check("minute",  {31'b0, minute_o},  {31'b0, e.mn});
            check("load",    {31'b0, load_o},    {31'b0, e.ld});
        end
    end

    initial begin
        repeat (3) tick();
        rst = 0;
        repeat (8) tick();

        year = 8'h23; month = 5'h05; day = 6'h17; wd = 3'd3;
        hour = 6'h14; minute = 7'h32; bst = 1'b1; warn = 1'b0;
        en = 1;
        run_until(30, 0, 2000);
        minute = 7'h33;
        run_until(59, CPS - 1, 2000);
        run_until(0, 0, 10);
        run_until(10, 7, 2000);
        en = 0;
        repeat (4) tick();

        rand_fields();
        en = 1;
        run_until(0, 3, 10);
        @(negedge clk);
        #1 rst = 1;
        #1;
        check("async_carrier", {31'b0, carrier_o}, 32'd1);
        check("async_sec",     {26'b0, sec_o},     32'd0);
        check("async_minute",  {31'b0, minute_o},  32'd0);
        tick();
        tick();
        rst = 0;
        en  = 0;
        repeat (3) tick();

        for (int r = 0; r < 3; r++) begin
            int len;
            rand_fields();
            en  = 1;
            len = $urandom_range(1300, 2600);
            for (int c = 0; c < len; c++) begin
                tick();
                if ($urandom_range(0, 99) == 0) rand_fields();
            end
            en = 0;
            repeat ($urandom_range(1, 4)) tick();
        end

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
